// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the sequential floating-point multiplier.
//   FP_NEXP / FP_NSIG : default exponent and stored-fraction widths
//   FP_BIAS / FP_M    : exponent bias and full significand width (hidden bit included)
//   FP_QNAN           : canonical quiet NaN for the default single-precision format
//   fp_state_t        : controller states
//   fp_class_t        : operand classification produced by fp_unpack
package fp_pkg;

  localparam int FP_NEXP = 8;
  localparam int FP_NSIG = 23;
  localparam int FP_BIAS = (1 << (FP_NEXP - 1)) - 1;
  localparam int FP_M    = FP_NSIG + 1;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_NORM_IN,
    S_MUL,
    S_NORM
  } fp_state_t;

  typedef enum logic [2:0] {
    CL_ZERO,
    CL_SUB,
    CL_NORM,
    CL_INF,
    CL_NAN
  } fp_class_t;

endpackage

// File: rtl/fp_mul_seq_unpack.sv
// fp_unpack: combinational operand decoder.
//   x       : packed operand {sign, exponent, fraction}
//   sgn     : operand sign
//   cls     : zero / subnormal / normal / infinity / NaN
//   exp_unb : unbiased exponent (1-BIAS for subnormals, 0 for zero/Inf/NaN)
//   sig     : M-bit significand, MSB is the hidden bit
module fp_unpack
  import fp_pkg::*;
#(
  parameter int NEXP = FP_NEXP,
  parameter int NSIG = FP_NSIG
) (
  input  logic [NEXP+NSIG:0]      x,
  output logic                    sgn,
  output fp_class_t               cls,
  output logic signed [NEXP+2:0]  exp_unb,
  output logic [NSIG:0]           sig
);

  localparam logic [NEXP+2:0] BIAS_V = (NEXP+3)'((1 << (NEXP - 1)) - 1);
  localparam logic [NEXP+2:0] SUB_E  = (NEXP+3)'(1) - BIAS_V;

  logic [NEXP-1:0] e;
  logic [NSIG-1:0] f;

  assign sgn = x[NEXP+NSIG];
  assign e   = x[NEXP+NSIG-1:NSIG];
  assign f   = x[NSIG-1:0];

  always_comb begin
    cls     = CL_NORM;
    exp_unb = '0;
    sig     = {1'b0, f};
    if (e == '0) begin
      if (f == '0) begin
        cls = CL_ZERO;
      end else begin
        cls     = CL_SUB;
        exp_unb = SUB_E;
      end
    end else if (e == '1) begin
      cls = (f == '0) ? CL_INF : CL_NAN;
    end else begin
      exp_unb = {3'b000, e} - BIAS_V;
      sig     = {1'b1, f};
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 multiplier front end.
// Multiplies significands with a shift-add datapath (one multiplier bit per
// cycle) and presents a normalized, unrounded result for a downstream packer.
// NaN / Inf / zero results bypass the packer via spec + special_y.
// Optional build macro FP_MUL_SUBNORM_EN: when defined, subnormal operands are
// pre-normalized (NORM_IN state) and multiplied exactly; otherwise they are
// flushed to zero.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   start        : request, sampled only while idle
//   a, b         : packed operands, captured on accepted start
//   busy         : operation in flight
//   done         : one-cycle completion pulse; outputs held until next start
//   yS           : result sign
//   E_unb        : unbiased exponent after normalization (signed, NEXP+3 bits)
//   mant_trunc   : truncated significand, MSB = hidden 1
//   G, Rb, S     : guard, round, sticky
//   spec         : use special_y instead of the packer fields
//   special_y    : packed special result
//   inv          : invalid operation
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int NEXP = FP_NEXP,
  parameter int NSIG = FP_NSIG
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NEXP+NSIG:0]      a,
  input  logic [NEXP+NSIG:0]      b,
  output logic                    busy,
  output logic                    done,
  output logic                    yS,
  output logic signed [NEXP+2:0]  E_unb,
  output logic [NSIG:0]           mant_trunc,
  output logic                    G,
  output logic                    Rb,
  output logic                    S,
  output logic                    spec,
  output logic [NEXP+NSIG:0]      special_y,
  output logic                    inv
);

  localparam int M  = NSIG + 1;
  localparam int W  = NEXP + NSIG + 1;
  localparam int CW = $clog2(M + 1);
  localparam logic signed [NEXP+2:0] ONE_E = 1;
  localparam logic [W-1:0] QNAN_V = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  fp_state_t state, state_next;

  logic [W-1:0] a_r, b_r;

  logic                   sgn_a, sgn_b;
  fp_class_t              ca, cb;
  logic signed [NEXP+2:0] ea_u, eb_u;
  logic [M-1:0]           sa_u, sb_u;

  logic signed [NEXP+2:0] ea, eb;
  logic [M-1:0]           sa, sb;
  logic [2*M-1:0]         p;
  logic [CW-1:0]          cnt;

  fp_unpack #(.NEXP(NEXP), .NSIG(NSIG)) u_unpack_a (
    .x(a_r), .sgn(sgn_a), .cls(ca), .exp_unb(ea_u), .sig(sa_u)
  );

  fp_unpack #(.NEXP(NEXP), .NSIG(NSIG)) u_unpack_b (
    .x(b_r), .sgn(sgn_b), .cls(cb), .exp_unb(eb_u), .sig(sb_u)
  );

  // Classification and special-result selection
  logic ys_c, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inv_c, special_c;
  logic [W-1:0] spec_val;

  assign ys_c  = sgn_a ^ sgn_b;
  assign a_nan = (ca == CL_NAN);
  assign b_nan = (cb == CL_NAN);
  assign a_inf = (ca == CL_INF);
  assign b_inf = (cb == CL_INF);
`ifdef FP_MUL_SUBNORM_EN
  assign a_zero = (ca == CL_ZERO);
  assign b_zero = (cb == CL_ZERO);
`else
  // Subnormals are flushed: they behave exactly like signed zeros.
  assign a_zero = (ca == CL_ZERO) || (ca == CL_SUB);
  assign b_zero = (cb == CL_ZERO) || (cb == CL_SUB);
`endif
  assign inv_c     = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign special_c = inv_c | a_inf | b_inf | a_zero | b_zero;

  always_comb begin
    spec_val = {ys_c, {(W-1){1'b0}}};
    if (inv_c)
      spec_val = QNAN_V;
    else if (a_inf || b_inf)
      spec_val = {ys_c, {NEXP{1'b1}}, {NSIG{1'b0}}};
  end

`ifdef FP_MUL_SUBNORM_EN
  // Input normalization step: both operands shift in parallel, each only
  // while its own MSB is still clear.
  logic                   need_norm, norm_ok;
  logic [M-1:0]           sa_sh, sb_sh;
  logic signed [NEXP+2:0] ea_sh, eb_sh;

  assign need_norm = ~sa_u[M-1] | ~sb_u[M-1];
  assign sa_sh     = sa[M-1] ? sa : {sa[M-2:0], 1'b0};
  assign sb_sh     = sb[M-1] ? sb : {sb[M-2:0], 1'b0};
  assign ea_sh     = sa[M-1] ? ea : ea - ONE_E;
  assign eb_sh     = sb[M-1] ? eb : eb - ONE_E;
  assign norm_ok   = sa_sh[M-1] & sb_sh[M-1];
`endif

  // Shift-add step: the low half of p initially holds the multiplier, so p[0]
  // is the current multiplier bit; the whole accumulator shifts right each cycle.
  logic [M:0]     acc_sum;
  logic [2*M-1:0] p_step;

  assign acc_sum = {1'b0, p[2*M-1:M]} + (p[0] ? {1'b0, sa} : {(M+1){1'b0}});
  assign p_step  = {acc_sum, p[M-1:1]};

  // Result normalization
  logic signed [NEXP+2:0] e_sum, e_n;
  logic [M-1:0]           mant_n;
  logic                   g_n, r_n, s_n;

  assign e_sum = ea + eb;

  always_comb begin
    if (p[2*M-1]) begin
      mant_n = p[2*M-1:M];
      g_n    = p[M-1];
      r_n    = p[M-2];
      s_n    = |p[M-3:0];
      e_n    = e_sum + ONE_E;
    end else begin
      mant_n = p[2*M-2:M-1];
      g_n    = p[M-2];
      r_n    = p[M-3];
      s_n    = |p[M-4:0];
      e_n    = e_sum;
    end
  end

  // Controller
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_UNPACK;
      S_UNPACK: begin
        if (special_c)
          state_next = S_IDLE;
`ifdef FP_MUL_SUBNORM_EN
        else if (need_norm)
          state_next = S_NORM_IN;
`endif
        else
          state_next = S_MUL;
      end
`ifdef FP_MUL_SUBNORM_EN
      S_NORM_IN: if (norm_ok) state_next = S_MUL;
`endif
      S_MUL:    if (cnt == '0) state_next = S_NORM;
      S_NORM:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r        <= '0;
      b_r        <= '0;
      ea         <= '0;
      eb         <= '0;
      sa         <= '0;
      sb         <= '0;
      p          <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      yS         <= 1'b0;
      E_unb      <= '0;
      mant_trunc <= '0;
      G          <= 1'b0;
      Rb         <= 1'b0;
      S          <= 1'b0;
      spec       <= 1'b0;
      special_y  <= '0;
      inv        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            busy <= 1'b1;
          end
        end
        S_UNPACK: begin
          if (special_c) begin
            yS         <= ys_c;
            spec       <= 1'b1;
            special_y  <= spec_val;
            inv        <= inv_c;
            E_unb      <= '0;
            mant_trunc <= '0;
            G          <= 1'b0;
            Rb         <= 1'b0;
            S          <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
          end else begin
            ea  <= ea_u;
            eb  <= eb_u;
            sa  <= sa_u;
            sb  <= sb_u;
            p   <= {{M{1'b0}}, sb_u};
            cnt <= CW'(M - 1);
          end
        end
`ifdef FP_MUL_SUBNORM_EN
        S_NORM_IN: begin
          ea  <= ea_sh;
          eb  <= eb_sh;
          sa  <= sa_sh;
          sb  <= sb_sh;
          p   <= {{M{1'b0}}, sb_sh};
          cnt <= CW'(M - 1);
        end
`endif
        S_MUL: begin
          p   <= p_step;
          cnt <= cnt - CW'(1);
        end
        S_NORM: begin
          yS         <= ys_c;
          spec       <= 1'b0;
          special_y  <= '0;
          inv        <= 1'b0;
          E_unb      <= e_n;
          mant_trunc <= mant_n;
          G          <= g_n;
          Rb         <= r_n;
          S          <= s_n;
          done       <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed-vector bench for fp_mul_seq (default single precision).
module tb_fp_mul_seq;
  import fp_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [31:0]        a = '0;
  logic [31:0]        b = '0;
  logic               busy, done, yS, G, Rb, S, spec, inv;
  logic signed [10:0] E_unb;
  logic [23:0]        mant_trunc;
  logic [31:0]        special_y;

  int n_checks = 0;
  int n_errors = 0;

  fp_mul_seq #(.NEXP(8), .NSIG(23)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .yS(yS), .E_unb(E_unb), .mant_trunc(mant_trunc),
    .G(G), .Rb(Rb), .S(S), .spec(spec), .special_y(special_y), .inv(inv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input string tag, input logic [31:0] ia, input logic [31:0] ib);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy_acc"}, 64'(busy), 64'd1);
  endtask

  // Counts edges after acceptance until done; optionally pokes a new start mid-MUL.
  task automatic wait_done(input string tag, input int exp_lat, input bit poke);
    int lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1 lat++;
      if (poke && lat == 10) begin
        a = 32'h4000_0000;
        b = 32'h4040_0000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  task automatic exp_norm(input string tag, input logic ys, input int e,
                          input logic [23:0] m, input logic [2:0] grs);
    check({tag, "_spec"}, {spec, inv, special_y}, 64'd0);
    check({tag, "_yS"}, 64'(yS), 64'(ys));
    check({tag, "_E"}, 64'(E_unb), 64'(e));
    check({tag, "_mant"}, 64'(mant_trunc), 64'(m));
    check({tag, "_grs"}, 64'({G, Rb, S}), 64'(grs));
  endtask

  task automatic exp_spec(input string tag, input logic ys, input logic [31:0] sy, input logic iv);
    check({tag, "_spec"}, 64'(spec), 64'd1);
    check({tag, "_sy"}, 64'(special_y), 64'(sy));
    check({tag, "_inv"}, 64'(inv), 64'(iv));
    check({tag, "_yS"}, 64'(yS), 64'(ys));
    check({tag, "_zero"}, {E_unb, mant_trunc, G, Rb, S}, 64'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] ia, input logic [31:0] ib, input int lat);
    launch(tag, ia, ib);
    wait_done(tag, lat, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {busy, done, spec, inv, yS, G, Rb, S}, 64'd0);
    check("rst_data", {E_unb, mant_trunc}, 64'd0);
    check("rst_sy", 64'(special_y), 64'd0);
    @(negedge clk) reset = 1'b0;

    // Normal products
    run("m15x15", 32'h3FC0_0000, 32'h3FC0_0000, 26);
    exp_norm("m15x15", 1'b0, 1, 24'h900000, 3'b000);
    run("m3xh", 32'hC040_0000, 32'h3F00_0000, 26);
    exp_norm("m3xh", 1'b1, 0, 24'hC00000, 3'b000);
    run("sticky", 32'h3F80_0001, 32'h3F80_0001, 26);
    exp_norm("sticky", 1'b0, 0, 24'h800002, 3'b001);
    run("guard", 32'h3FC0_0001, 32'h3FC0_0001, 26);
    exp_norm("guard", 1'b0, 1, 24'h900001, 3'b101);
    run("round", 32'h3F80_0003, 32'h3FA0_0000, 26);
    exp_norm("round", 1'b0, 0, 24'hA00003, 3'b110);
    run("big", 32'h7F00_0000, 32'h7F00_0000, 26);
    exp_norm("big", 1'b0, 254, 24'h800000, 3'b000);
    run("tiny", 32'h8080_0000, 32'h0080_0000, 26);
    exp_norm("tiny", 1'b1, -252, 24'h800000, 3'b000);

    // Special cases
    run("infx0", 32'h7F80_0000, 32'h0000_0000, 1);
    exp_spec("infx0", 1'b0, FP_QNAN, 1'b1);
    run("nan", 32'hFFC0_0000, 32'h3F80_0000, 1);
    exp_spec("nan", 1'b1, FP_QNAN, 1'b1);
    run("0xinf", 32'h8000_0000, 32'h7F80_0000, 1);
    exp_spec("0xinf", 1'b1, FP_QNAN, 1'b1);
    run("infxn", 32'h7F80_0000, 32'hC000_0000, 1);
    exp_spec("infxn", 1'b1, 32'hFF80_0000, 1'b0);
    run("zxn", 32'h8000_0000, 32'h4040_0000, 1);
    exp_spec("zxn", 1'b1, 32'h8000_0000, 1'b0);

    // Subnormal operands
`ifdef FP_MUL_SUBNORM_EN
    run("sub1", 32'h0000_0001, 32'h3F80_0000, 49);
    exp_norm("sub1", 1'b0, -149, 24'h800000, 3'b000);
    run("sub2", 32'h0020_0000, 32'h0040_0000, 28);
    exp_norm("sub2", 1'b0, -255, 24'h800000, 3'b000);
    run("subinf", 32'h0000_0001, 32'h7F80_0000, 1);
    exp_spec("subinf", 1'b0, 32'h7F80_0000, 1'b0);
`else
    run("sub1", 32'h0000_0001, 32'h3F80_0000, 1);
    exp_spec("sub1", 1'b0, 32'h0000_0000, 1'b0);
    run("sub2", 32'h0020_0000, 32'h8040_0000, 1);
    exp_spec("sub2", 1'b1, 32'h8000_0000, 1'b0);
    run("subinf", 32'h0000_0001, 32'h7F80_0000, 1);
    exp_spec("subinf", 1'b0, FP_QNAN, 1'b1);
`endif

    // Start pulse while busy must be ignored
    launch("poke", 32'h3FC0_0000, 32'h3FC0_0000);
    wait_done("poke", 26, 1'b1);
    exp_norm("poke", 1'b0, 1, 24'h900000, 3'b000);

    // Reset in the middle of MUL aborts the operation
    launch("abort", 32'hC040_0000, 32'h3F00_0000);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    check("abort_ctl", {busy, done, spec, inv, yS, G, Rb, S}, 64'd0);
    check("abort_data", {E_unb, mant_trunc}, 64'd0);
    @(negedge clk) reset = 1'b0;
    run("after", 32'hC040_0000, 32'h3F00_0000, 26);
    exp_norm("after", 1'b1, 0, 24'hC00000, 3'b000);

    // done is a single-cycle pulse with outputs held afterwards
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done), 64'd0);
    check("hold", 64'(mant_trunc), 64'h0000_0000_00C0_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Sequential IEEE-754 multiplier front end. It accepts two packed operands and multiplies the significands with an iterative shift-add datapath, one bit per cycle. It then hands the packer a normalized result: sign, unbiased exponent, truncated significand, and the G/R/S bits. NaN, Inf and zero cases bypass the packer on a separate special-result port.

## Interface
- NEXP, 8, exponent width
- NSIG, 23, stored fraction width (M = NSIG+1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled only while idle
- a, b  in  NEXP+NSIG+1 each  packed operands, captured on accepted start
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; all result outputs valid and held until next accepted start
- yS  out  1  result sign
- E_unb  out  NEXP+3 signed  unbiased exponent after normalization
- mant_trunc  out  M  significand, MSB = implicit 1
- G, Rb, S  out  1 each  guard, round, sticky
- spec  out  1  1 = use special_y and ignore packer fields
- special_y  out  NEXP+NSIG+1  packed special result
- inv  out  1  invalid operation (NaN operand or Inf×0)

## Operation
- Sign: yS = a sign XOR b sign, for all cases including specials.
- FSM states:
  - IDLE: start=1 captures a and b and goes to UNPACK.
  - UNPACK: classifies the operands. A special case writes its outputs, pulses done and returns to IDLE. Otherwise go to NORM_IN if a significand MSB is 0 (macro on), else MUL.
  - NORM_IN: shifts each unnormalized significand left 1 bit/cycle and decrements its exponent, until both MSBs are 1, then MUL.
  - MUL: 2M-bit accumulator P, one multiplier bit per cycle, M cycles, then NORM.
  - NORM: writes the outputs, pulses done, returns to IDLE.
- Unbiased operand exponent: Ex = exp − BIAS for normals; subnormals use 1 − BIAS, minus the shift count.
- Special cases:
  - Either operand NaN, or Inf×0: special_y = 0x7FC00000-form canonical qNaN (sign 0, exponent all-ones, fraction MSB set), inv=1.
  - Inf×nonzero: ±Inf.
  - Zero×finite: ±0.
- NORM, when P[2M−1]=1:
  - mant_trunc = P[2M−1:M]; G = P[M−1]; Rb = P[M−2]; S = |P[M−3:0]
  - E_unb = Ea+Eb+1
- NORM, otherwise:
  - mant_trunc = P[2M−2:M−1]; G = P[M−2]; Rb = P[M−3]; S = |P[M−4:0]
  - E_unb = Ea+Eb
- E_unb never saturates: range overflow/underflow is the packer's job. The NEXP+3 width holds every reachable sum.
- On a non-special result: spec=0, special_y=0, inv=0.
- On a special result: mant_trunc, G, Rb, S and E_unb are 0.
- start while busy is ignored; operands are not recaptured.

## Timing
- Reset: state IDLE; busy, done, spec, inv, yS, G, Rb, S = 0; E_unb, mant_trunc, special_y = 0.
- Reset mid-operation aborts immediately. No done is produced for the aborted operation.
- Latency from the edge accepting start (edge k):
  - Special: outputs and done after edge k+1.
  - Normal operands: after edge k+M+2 (26 for defaults).
  - Subnormal operands: add one cycle per NORM_IN shift.
- busy: high from edge k until the edge that raises done. Low while done=1.
- start may be asserted in the done cycle and is accepted (back-to-back operation).
- Outputs change only at edges that raise done.

## Configuration
- FP_MUL_SUBNORM_EN defined: NORM_IN is present, and subnormal inputs are normalized and multiplied exactly.
- FP_MUL_SUBNORM_EN undefined: subnormal inputs are flushed to zero in UNPACK (zero×finite gives signed zero; ×Inf gives qNaN with inv=1). NORM_IN is not compiled.

## Structure
- Package fp_pkg holds:
  - NEXP/NSIG defaults, BIAS, M
  - state enum {IDLE, UNPACK, NORM_IN, MUL, NORM}
  - QNAN constant and class enum {ZERO, SUB, NORM, INF, NAN}
- Sub-module fp_unpack is combinational: one packed operand in; class, unbiased exponent and M-bit significand out. Instantiated twice.

## Test plan
- a=0x3FC00000 (1.5), b=0x3FC00000 -> after 26 cycles: done=1, yS=0, E_unb=1, mant_trunc=0x900000, G=Rb=S=0, spec=0.
- a=0xC0400000 (−3.0), b=0x3F000000 (0.5) -> yS=1, E_unb=0, mant_trunc=0xC00000, G=Rb=S=0.
- a=0x7F800000, b=0x00000000 -> done after 1 cycle: spec=1, special_y=0x7FC00000, inv=1.
- a=0x00000001, b=0x3F800000:
  - Macro on: E_unb=−149, mant_trunc=0x800000, done after 49 cycles.
  - Macro off: spec=1, special_y=0x00000000, done after 1 cycle.
- Pulse start with new operands mid-MUL -> ignored; the result matches the first operands.
- Assert reset mid-MUL, then start a new operation -> no done until the new latency elapses; the result is correct.
